// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and address-split helpers for icache_fetch
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_t;

    // Pipeline NOP: opcode 6'b110001 with an all-zero body
    localparam logic [31:0] NOP_INSTR = 32'hC400_0000;

    function automatic int offBits(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int idxBits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tagBits(input int lines, input int lineWords);
        return 30 - $clog2(lineWords) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// rtl/icache_data_ram.sv - instruction data array, synchronous write port and asynchronous read port
module icache_data_ram #(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [WORDS];

    // Fill writes land one word per acked cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped read-only instruction cache for the fetch stage; optional counters under ICACHE_PERF_EN
module icache_fetch
    import icache_pkg::*;
#(
    parameter int          LINES      = 16,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] NOP_INSTR  = icache_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic        miss_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF       = offBits(LINE_WORDS);
    localparam int IDX       = idxBits(LINES);
    localparam int TAG       = tagBits(LINES, LINE_WORDS);
    localparam int LINE_BITS = TAG + IDX;

    fillState_t           state;
    fillState_t           stateNext;
    logic [LINES-1:0]     valid;
    logic [TAG-1:0]       tagArr [LINES];
    logic [LINE_BITS-1:0] missLine;
    logic [OFF-1:0]       cnt;
    logic                 flushPend;

    logic [OFF-1:0]       pcOff;
    logic [IDX-1:0]       pcIdx;
    logic [TAG-1:0]       pcTag;
    logic [IDX-1:0]       fillIdx;
    logic [TAG-1:0]       fillTag;
    logic                 hit;
    logic                 startFill;
    logic                 fillAck;
    logic                 lastAck;
    logic [31:0]          rdWord;
    logic                 unusedPcBits;

    assign pcOff        = pc_f[2 +: OFF];
    assign pcIdx        = pc_f[2 + OFF +: IDX];
    assign pcTag        = pc_f[31 -: TAG];
    assign fillIdx      = missLine[IDX-1:0];
    assign fillTag      = missLine[LINE_BITS-1 -: TAG];
    assign unusedPcBits = ^pc_f[1:0];

    // A flush cycle never hits, so it cannot feed stale data to decode
    assign hit       = (state == IDLE) && !flush && valid[pcIdx] && (tagArr[pcIdx] == pcTag);
    assign startFill = (state == IDLE) && !hit && !flush;
    assign fillAck   = (state == FILL) && mem_ack;
    assign lastAck   = fillAck && (cnt == OFF'(LINE_WORDS - 1));

    icache_data_ram #(
        .WORDS  (LINES * LINE_WORDS),
        .ADDR_W (IDX + OFF)
    ) u_data_ram (
        .clk   (clk),
        .we    (fillAck),
        .waddr ({fillIdx, cnt}),
        .wdata (mem_rdata),
        .raddr ({pcIdx, pcOff}),
        .rdata (rdWord)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and lookup/memory outputs
    always_comb begin
        stateNext  = state;
        instr_f    = NOP_INSTR;
        miss_stall = 1'b1;
        mem_req    = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    instr_f    = rdWord;
                    miss_stall = 1'b0;
                end
                if (startFill) begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {missLine, cnt, 2'b00};
                if (lastAck) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Fill bookkeeping: line latch, word counter, flush-during-fill marker
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            flushPend <= 1'b0;
        end else begin
            if (startFill) begin
                missLine  <= pc_f[31:2+OFF];
                cnt       <= '0;
                flushPend <= 1'b0;
            end
            if (fillAck) begin
                cnt <= cnt + OFF'(1);
            end
            if ((state == FILL) && flush) begin
                flushPend <= 1'b1;
            end
            if (lastAck) begin
                flushPend <= 1'b0;
            end
        end
    end

    // Valid bits: flush wins over a completing fill, flushed fills stay invalid
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= '0;
        end else if (lastAck && !flushPend) begin
            valid[fillIdx] <= 1'b1;
        end
    end

    // Tag written when the line completes; guarded by its valid bit
    always_ff @(posedge clk) begin
        if (lastAck) begin
            tagArr[fillIdx] <= fillTag;
        end
    end

`ifdef ICACHE_PERF_EN
    // Hit cycles and fill starts, free-running until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (startFill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - scoreboard bench for icache_fetch against a line-level cache model
module tb_icache_fetch;

    localparam int          LINES = 16;
    localparam int          LW    = 4;
    localparam logic [31:0] NOP   = 32'hC400_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_f = '0;
    logic [31:0] instr_f;
    logic        miss_stall;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .pc_f       (pc_f),
        .instr_f    (instr_f),
        .miss_stall (miss_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] instr;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    // Reference model: which memory line each index holds, plus fill progress
    bit          mValid [LINES];
    int unsigned mLine  [LINES];
    bit          modelKnown  = 0;
    bit          fillActive  = 0;
    bit          bubble      = 0;
    bit          fillFlushed = 0;
    int unsigned fillLine    = 0;
    int          wordsDone   = 0;
    int unsigned hitCount    = 0;
    int unsigned missCount   = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; expectation for this cycle goes on the queue
    task automatic step(input logic [31:0] pc, input bit fl, input bit rst, input int ackPct);
        bit          ack;
        bit          idle;
        bit          hitE;
        int unsigned lineNum;
        int          idx;
        logic [31:0] curAddr;
        exp_t        e;
        @(negedge clk);
        ack     = ($urandom_range(0, 99) < ackPct);
        pc_f    = pc;
        flush   = fl;
        reset   = rst;
        mem_ack = ack;
        idle    = !fillActive && !bubble;
        lineNum = pc >> 4;
        idx     = int'(lineNum % LINES);
        hitE    = idle && !fl && mValid[idx] && (mLine[idx] == lineNum);
        curAddr = fillActive ? (fillLine * LW + wordsDone) * 4 : 32'h0;
        mem_rdata = fillActive ? memWord(curAddr) : $urandom();
        if (modelKnown) begin
            e.stall = !hitE;
            e.instr = hitE ? memWord(pc) : NOP;
            e.req   = fillActive;
            e.addr  = curAddr;
            expQ.push_back(e);
        end
        if (rst) begin
            foreach (mValid[i]) mValid[i] = 0;
            fillActive = 0;
            bubble     = 0;
            modelKnown = 1;
            hitCount   = 0;
            missCount  = 0;
        end else begin
            if (hitE) hitCount++;
            if (fl) begin
                foreach (mValid[i]) mValid[i] = 0;
                if (fillActive) fillFlushed = 1;
            end
            if (idle) begin
                if (!hitE && !fl) begin
                    fillActive  = 1;
                    fillLine    = lineNum;
                    wordsDone   = 0;
                    fillFlushed = 0;
                    missCount++;
                end
            end else if (fillActive) begin
                if (ack) begin
                    wordsDone++;
                    if (wordsDone == LW) begin
                        fillActive = 0;
                        bubble     = 1;
                        if (!fillFlushed && !fl) begin
                            mValid[fillLine % LINES] = 1;
                            mLine[fillLine % LINES]  = fillLine;
                        end
                    end
                end
            end else begin
                bubble = 0;
            end
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("miss_stall", {31'd0, miss_stall}, {31'd0, e.stall});
                chk("instr_f", instr_f, e.instr);
                chk("mem_req", {31'd0, mem_req}, {31'd0, e.req});
                chk("mem_addr", mem_addr, e.addr);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        step(32'h0, 0, 1, 0);
        step(32'h0, 0, 1, 0);
        // Cold miss on 0x0 then a hit on a neighbouring word
        for (int i = 0; i < 8; i++) step(32'h0, 0, 0, 100);
        for (int i = 0; i < 3; i++) step(32'h8, 0, 0, 100);
        // Conflict on the same index
        for (int i = 0; i < 8; i++) step(32'h100, 0, 0, 100);
        for (int i = 0; i < 8; i++) step(32'h0, 0, 0, 100);
        // Flush in the second fill cycle
        step(32'h300, 0, 0, 100);
        step(32'h300, 0, 0, 100);
        step(32'h300, 1, 0, 100);
        for (int i = 0; i < 10; i++) step(32'h300, 0, 0, 100);
        // PC moves mid-fill
        for (int i = 0; i < 2; i++) step(32'h40, 0, 0, 100);
        for (int i = 0; i < 12; i++) step(32'h200, 0, 0, 100);
        // Reset during word 2 of a fill
        for (int i = 0; i < 3; i++) step(32'h500, 0, 0, 100);
        step(32'h500, 0, 1, 100);
        for (int i = 0; i < 3; i++) step(32'h0, 0, 0, 100);
        for (int i = 0; i < 8; i++) step(32'h500, 0, 0, 100);
        // Miss followed by a run of hit cycles
        for (int i = 0; i < 12; i++) step(32'h604, 0, 0, 100);
        // Randomized traffic with slow acks, flushes and resets
        pc = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 20) begin
                pc = {($urandom_range(0, 1) == 1) ? 20'hABCDE : 20'h00000,
                      2'b00, 10'($urandom_range(0, 1023))};
            end
            step(pc, ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0), 60);
        end
        step(pc, 0, 0, 100);
        @(negedge clk);
        #3;
`ifdef ICACHE_PERF_EN
        chk("hit_cnt", hit_cnt, hitCount);
        chk("miss_cnt", miss_cnt, missCount);
`endif
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
